// File: rtl/demux_stream_1ton_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | demux_stream_pkg                                                           |
// | Shared constants and helpers for the 1-to-N stream demultiplexer.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package demux_stream_pkg;

  localparam int MAX_CH = 16;

  // Select field is never narrower than one bit, even for a single channel.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_stream_1ton_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | demux_stream_1ton_if                                                       |
// | Producer-side stream plus NUM_CH consumer channels of the demultiplexer.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface demux_stream_1ton_if
  import demux_stream_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
) ();

  localparam int SEL_W = sel_width(NUM_CH);

  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_data;
  logic [SEL_W-1:0]        in_select;
  logic                    in_bcast;
  logic [NUM_CH-1:0]       out_valid;
  logic [NUM_CH-1:0]       out_ready;
  logic [NUM_CH*WIDTH-1:0] out_data;
  logic                    err_sel;

  modport slave (
    input  in_valid, in_data, in_select, in_bcast, out_ready,
    output in_ready, out_valid, out_data, err_sel
  );

  modport master (
    output in_valid, in_data, in_select, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, err_sel
  );

endinterface
`default_nettype wire

// File: rtl/demux_stream_1ton_chan_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | demux_chan_reg                                                             |
// | One-entry valid/data holding register for a single output channel.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module demux_chan_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_out_ready,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_free
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Free also when the held word leaves this cycle, allowing drain-and-refill.
  assign o_free      = ~r_valid | i_out_ready;
  assign o_out_valid = r_valid;
  assign o_out_data  = r_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_load_data;
    end else if (i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/demux_stream_1ton.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | demux_stream_1ton                                                          |
// | Registered 1-to-N stream demultiplexer with broadcast and bad-select flag. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module demux_stream_1ton
  import demux_stream_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  demux_stream_1ton_if.slave    io_strm
);

  localparam int SEL_W = sel_width(NUM_CH);

  logic [NUM_CH-1:0] w_free;
  logic [NUM_CH-1:0] w_hit;
  logic [NUM_CH-1:0] w_load;
  logic              w_sel_free;
  logic              w_sel_ok;
  logic              w_all_free;
  logic              w_accept;
  logic              r_err_sel;

  always_comb begin
    w_hit      = '0;
    w_sel_free = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (io_strm.in_select == SEL_W'(k)) begin
        w_hit[k]   = 1'b1;
        w_sel_free = w_free[k];
      end
    end
  end

  assign w_sel_ok   = |w_hit;
  assign w_all_free = &w_free;

  // Out-of-range selects are swallowed so a bad producer cannot wedge the input.
  always_comb begin
    io_strm.in_ready = 1'b0;
    if (rst_n) begin
      if (io_strm.in_bcast)
        io_strm.in_ready = w_all_free;
      else if (w_sel_ok)
        io_strm.in_ready = w_sel_free;
      else
        io_strm.in_ready = 1'b1;
    end
  end

  assign w_accept = io_strm.in_valid & io_strm.in_ready;

  always_comb begin
    w_load = '0;
    if (w_accept)
      w_load = io_strm.in_bcast ? {NUM_CH{1'b1}} : w_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_err_sel <= 1'b0;
    else
      r_err_sel <= w_accept & ~io_strm.in_bcast & ~w_sel_ok;
  end

  assign io_strm.err_sel = r_err_sel;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    demux_chan_reg #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_load[k]),
      .i_load_data (io_strm.in_data),
      .i_out_ready (io_strm.out_ready[k]),
      .o_out_valid (io_strm.out_valid[k]),
      .o_out_data  (io_strm.out_data[k*WIDTH +: WIDTH]),
      .o_free      (w_free[k])
    );
  end

endmodule
`default_nettype wire
